// File: rtl/ring_osc_trim_model_if.sv
// Signal bundle between the ring-oscillator model and its user: trim code in,
// two phase clocks and the running indication out.
interface ring_osc_trim_model_if;
  logic [25:0] trim;
  logic [1:0]  clockp;
  logic        running;

  // Consumer side: drives the trim code, observes the phase clocks.
  modport master (
    output trim,
    input  clockp,
    input  running
  );

  // Oscillator side: samples the trim code, drives the phase clocks.
  modport slave (
    input  trim,
    output clockp,
    output running
  );
endinterface

// File: rtl/ring_osc_trim_model.sv
// Clocked functional model of a trimmable 13-stage two-phase ring oscillator.
// An internal "hiclock" toggles every D = BASE_DELAY + TRIM_STEP*popcount(trim)
// reference cycles; its rising edge toggles the 0-degree clock and its falling
// edge toggles the 90-degree clock, giving two quadrature clocks of period 4D.
// The trim code is latched only when hiclock toggles, so a half-period is
// never truncated or stretched by a trim change.

// Invariant checker for the oscillator core, kept apart from the datapath.
module ring_osc_trim_model_chk (
  input logic       clk,
  input logic       rst,
  input logic       run,
  input logic       hiclock,
  input logic [7:0] cnt,
  input logic [7:0] half,
  input logic [1:0] clockp
);
  // Nothing may oscillate before start-up completes.
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    !run |-> (clockp == 2'b00) && (hiclock == 1'b0));

  // The half-period counter never runs past the current half-period length.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt < half);

  // The quadrature sequence 00 -> 01 -> 11 -> 10 keeps hiclock = cp0 ^ cp1.
  a_phase_rel: assert property (@(posedge clk) disable iff (rst)
    (clockp[0] ^ clockp[1]) == hiclock);

  // At most one phase clock changes per reference edge.
  a_one_change: assert property (@(posedge clk) disable iff (rst)
    $onehot0(clockp ^ $past(clockp)));

  // The half-period length is never zero.
  a_half_nonzero: assert property (@(posedge clk) disable iff (rst)
    half != 8'd0);
endmodule

module ring_osc_trim_model #(
  parameter int BASE_DELAY   = 24,
  parameter int TRIM_STEP    = 1,
  parameter int NRESET_DELAY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  ring_osc_trim_model_if.slave         bus
);

  // Start counter runs 0 .. NRESET_DELAY-1; the edge that finds it at the
  // last value is the NRESET_DELAY-th edge after reset release.
  localparam int          LP_SC_W      = (NRESET_DELAY > 1) ? $clog2(NRESET_DELAY) : 1;
  localparam logic [LP_SC_W-1:0] LP_START_LAST = LP_SC_W'(NRESET_DELAY - 1);
  localparam logic [7:0]  LP_BASE      = 8'(BASE_DELAY);
  localparam logic [7:0]  LP_STEP      = 8'(TRIM_STEP);

  // Number of set bits in the trim code; bit position carries no weight.
  function automatic logic [4:0] f_popcount26(input logic [25:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 26; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  logic [LP_SC_W-1:0] r_start_cnt;
  logic               r_run;
  logic [25:0]        r_ltrim;
  logic [7:0]         r_cnt;
  logic               r_hiclock;
  logic [1:0]         r_clockp;

  logic [4:0]         w_pop;
  logic [7:0]         w_half;
  logic [7:0]         w_half_m1;
  logic               w_start_done;
  logic               w_toggle;

  // Half-period length from the latched trim, in 8-bit unsigned arithmetic.
  always_comb begin
    w_pop     = f_popcount26(r_ltrim);
    w_half    = LP_BASE + (LP_STEP * {3'd0, w_pop});
    w_half_m1 = w_half - 8'd1;
  end

  // Start-up completion and half-period boundary detection.
  always_comb begin
    w_start_done = 1'b0;
    w_toggle     = 1'b0;
    if (r_run) begin
      w_toggle = (r_cnt == w_half_m1);
    end else begin
      w_start_done = (r_start_cnt == LP_START_LAST);
    end
  end

  // Post-reset start-up delay; run stays set until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_cnt <= '0;
      r_run       <= 1'b0;
    end else if (w_start_done) begin
      r_run <= 1'b1;
    end else if (!r_run) begin
      r_start_cnt <= r_start_cnt + LP_SC_W'(1);
    end else begin
      r_run <= 1'b1;
    end
  end

  // Half-period counter, hiclock and trim latch; trim is only sampled at
  // start-up and at hiclock toggles so each half-period keeps its length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 8'd0;
      r_hiclock <= 1'b0;
      r_ltrim   <= 26'd0;
    end else if (w_start_done) begin
      r_cnt   <= 8'd0;
      r_ltrim <= bus.trim;
    end else if (w_toggle) begin
      r_cnt     <= 8'd0;
      r_hiclock <= ~r_hiclock;
      r_ltrim   <= bus.trim;
    end else if (r_run) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Phase generation: hiclock rising toggles 0-degree, falling toggles 90-degree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clockp <= 2'b00;
    end else if (w_toggle) begin
      if (!r_hiclock) begin
        r_clockp[0] <= ~r_clockp[0];
      end else begin
        r_clockp[1] <= ~r_clockp[1];
      end
    end else begin
      r_clockp <= r_clockp;
    end
  end

  assign bus.clockp  = r_clockp;
  assign bus.running = r_run;

  ring_osc_trim_model_chk u_chk (
    .clk     (clk),
    .rst     (reset),
    .run     (r_run),
    .hiclock (r_hiclock),
    .cnt     (r_cnt),
    .half    (w_half),
    .clockp  (r_clockp)
  );

endmodule

// File: tb/tb_ring_osc_trim_model.sv
// Directed bench for ring_osc_trim_model: records the reference-edge number
// of every phase-clock transition and compares against hand-computed edges.
module tb_ring_osc_trim_model;

  logic clk;
  logic reset;

  ring_osc_trim_model_if bus_a ();
  ring_osc_trim_model_if bus_b ();

  // Default-parameter instance (BASE 24, STEP 1, NRESET 4).
  ring_osc_trim_model u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  // Minimum-delay instance (BASE 1, NRESET 1).
  ring_osc_trim_model #(
    .BASE_DELAY   (1),
    .TRIM_STEP    (1),
    .NRESET_DELAY (1)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_checks   = 0;
  int n_failures = 0;

  int edge_cnt = 0;
  int rise_q [4][$];   // index = dut*2 + phase bit
  int fall_q [4][$];
  int run_edge [2];
  logic [1:0] prev_cp [2];
  logic       prev_run [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count edges since reset release and log transitions just after each edge.
  always @(posedge clk) begin
    if (reset) begin
      edge_cnt = 0;
      for (int q = 0; q < 4; q++) begin
        rise_q[q].delete();
        fall_q[q].delete();
      end
      for (int d = 0; d < 2; d++) begin
        run_edge[d] = -1;
        prev_cp[d]  = 2'b00;
        prev_run[d] = 1'b0;
      end
    end else begin
      logic [1:0] cp [2];
      logic       rn [2];
      edge_cnt = edge_cnt + 1;
      #1;
      cp[0] = bus_a.clockp;  rn[0] = bus_a.running;
      cp[1] = bus_b.clockp;  rn[1] = bus_b.running;
      for (int d = 0; d < 2; d++) begin
        for (int b = 0; b < 2; b++) begin
          if (cp[d][b] && !prev_cp[d][b]) rise_q[d*2+b].push_back(edge_cnt);
          if (!cp[d][b] && prev_cp[d][b]) fall_q[d*2+b].push_back(edge_cnt);
        end
        if (rn[d] && !prev_run[d] && run_edge[d] < 0) run_edge[d] = edge_cnt;
        prev_cp[d]  = cp[d];
        prev_run[d] = rn[d];
      end
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_failures = n_failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_rise(input int id, input int k);
    if (k < rise_q[id].size()) return rise_q[id][k];
    return -1;
  endfunction

  function automatic int q_fall(input int id, input int k);
    if (k < fall_q[id].size()) return fall_q[id][k];
    return -1;
  endfunction

  // Pulse reset across one clk edge and release it before edge 1.
  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to just after edge n (bounded).
  task automatic run_to(input int n);
    for (int i = 0; i < 2000 && edge_cnt < n; i++) begin
      @(posedge clk);
      #2;
    end
    if (edge_cnt < n) check_val("run_to_timeout", edge_cnt, n);
  endtask

  initial begin
    reset       = 1'b1;
    bus_a.trim  = 26'd0;
    bus_b.trim  = 26'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_clockp_a",  int'(bus_a.clockp),  0);
    check_val("rst_running_a", int'(bus_a.running), 0);
    check_val("rst_clockp_b",  int'(bus_b.clockp),  0);
    check_val("rst_running_b", int'(bus_b.running), 0);

    // Defaults, trim = 0 (D = 24); minimum instance D = 1 alongside.
    reset_pulse();
    run_to(130);
    check_val("def_running_edge", run_edge[0], 4);
    check_val("def_cp0_rise0",    q_rise(0, 0), 28);
    check_val("def_cp0_fall0",    q_fall(0, 0), 76);
    check_val("def_cp0_rise1",    q_rise(0, 1), 124);
    check_val("def_cp1_rise0",    q_rise(1, 0), 52);
    check_val("def_cp1_fall0",    q_fall(1, 0), 100);
    check_val("min_running_edge", run_edge[1], 1);
    check_val("min_cp0_rise0",    q_rise(2, 0), 2);
    check_val("min_cp0_fall0",    q_fall(2, 0), 4);
    check_val("min_cp0_period",   q_rise(2, 1) - q_rise(2, 0), 4);
    check_val("min_cp1_rise0",    q_rise(3, 0), 3);
    check_val("min_cp1_fall0",    q_fall(3, 0), 5);

    // All trim bits set: D = 50.
    bus_a.trim = 26'h3FFFFFF;
    reset_pulse();
    run_to(260);
    check_val("max_cp0_rise0",  q_rise(0, 0), 54);
    check_val("max_cp0_period", q_rise(0, 1) - q_rise(0, 0), 200);
    check_val("max_cp0_high",   q_fall(0, 0) - q_rise(0, 0), 100);
    check_val("max_cp1_lag",    q_rise(1, 0) - q_rise(0, 0), 50);

    // Popcount 1 with the lowest bit: D = 25.
    bus_a.trim = 26'h0000001;
    reset_pulse();
    run_to(135);
    check_val("lsb_cp0_rise0", q_rise(0, 0), 29);
    check_val("lsb_cp0_fall0", q_fall(0, 0), 79);
    check_val("lsb_cp0_rise1", q_rise(0, 1), 129);
    check_val("lsb_cp1_rise0", q_rise(1, 0), 54);

    // Popcount 1 with the highest bit: identical timing.
    bus_a.trim = 26'h2000000;
    reset_pulse();
    run_to(135);
    check_val("msb_cp0_rise0", q_rise(0, 0), 29);
    check_val("msb_cp0_fall0", q_fall(0, 0), 79);
    check_val("msb_cp0_rise1", q_rise(0, 1), 129);
    check_val("msb_cp1_rise0", q_rise(1, 0), 54);

    // Trim 0 -> all ones 10 cycles into the half-period starting at edge 28.
    bus_a.trim = 26'd0;
    reset_pulse();
    run_to(38);
    bus_a.trim = 26'h3FFFFFF;
    run_to(210);
    check_val("sw_cp0_rise0", q_rise(0, 0), 28);
    check_val("sw_cp1_rise0", q_rise(1, 0), 52);
    check_val("sw_cp0_fall0", q_fall(0, 0), 102);
    check_val("sw_cp1_fall0", q_fall(1, 0), 152);
    check_val("sw_cp0_rise1", q_rise(0, 1), 202);

    // Reset in the middle of the high phase, between edges.
    bus_a.trim = 26'd0;
    reset_pulse();
    run_to(40);
    check_val("mid_pre_clockp", int'(bus_a.clockp), 1);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_async_clockp",  int'(bus_a.clockp),  0);
    check_val("mid_async_running", int'(bus_a.running), 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    reset = 1'b0;
    run_to(60);
    check_val("mid_running_edge", run_edge[0], 4);
    check_val("mid_cp0_rise0",    q_rise(0, 0), 28);
    check_val("mid_cp1_rise0",    q_rise(1, 0), 52);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/ring_osc_trim_model.md
Name: ring_osc_trim_model

Overview:
- Clocked, synthesizable functional model of the trimmable 13-stage two-phase ring oscillator.
- Generates two phase clocks, 0° and 90°, derived from a reference clock.
- Output period is set by the number of set trim bits.
- Trim is latched only at half-period boundaries, so a period is never shortened or glitched.
- Outputs are held low, as by an AND-type gate, until a post-reset start-up delay expires.
- Used in place of the analog ring oscillator in digital simulation and FPGA prototyping of the clocking block.

Parameters:
- BASE_DELAY, 24, half-period of the internal high clock in clk cycles at trim popcount 0; legal range ≥ 1.
- TRIM_STEP, 1, clk cycles added to the half-period per set trim bit; BASE_DELAY + 26*TRIM_STEP must be ≤ 255.
- NRESET_DELAY, 4, clk cycles after reset release before the oscillator core starts; legal range ≥ 1.

Ports:
- clk, input, 1, reference clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- trim, input, 26, trim bits; only the popcount matters; bit position is irrelevant.
- clockp, output, 2, [0] = 0° phase clock, [1] = 90° phase clock; both registered.
- running, output, 1, high once the start-up delay has expired and the core is oscillating.

Behaviour:
- Internal state:
  - start counter (to NRESET_DELAY)
  - run flag
  - latched trim ltrim[25:0]
  - 8-bit half-period counter cnt
  - hiclock bit
  - clockp[1:0]
- Half-period D = BASE_DELAY + TRIM_STEP * popcount(ltrim), computed in 8-bit unsigned arithmetic.
- Reset asserted (asynchronous, any time, including mid-period):
  - clockp = 2'b00, running = 0, hiclock = 0, cnt = 0, ltrim = 0, start counter = 0.
  - Takes effect immediately, without waiting for a clk edge.
- Start-up after reset release:
  - The start counter counts clk edges.
  - On the NRESET_DELAY-th edge: run <= 1, running <= 1, ltrim <= trim, cnt <= 0.
  - clockp stays 0 throughout start-up.
- Running, on each clk edge:
  - If cnt == D-1: cnt <= 0; hiclock toggles; ltrim <= trim, so the new D applies to the next half-period.
  - Otherwise cnt <= cnt + 1.
- Phase generation:
  - hiclock 0→1 toggles clockp[0].
  - hiclock 1→0 toggles clockp[1].
  - Both update on the same edge as the hiclock toggle.
- Resulting timing, with reset released before edge 1:
  - clockp[0] first rises at edge NRESET_DELAY + D.
  - clockp[1] first rises at edge NRESET_DELAY + 2D.
  - Each clockp has period 4D and 50% duty cycle when trim is static.
  - clockp[1] lags clockp[0] by D cycles (90°).
- Trim changes:
  - A trim change mid half-period has no effect until the next hiclock toggle (edge-inhibit behaviour).
  - Current half-periods are never truncated or extended.
  - Neither output ever produces a pulse shorter than min(D_old, D_new) clk cycles.
- Trim applied during start-up: the value present on the NRESET_DELAY-th edge is used.
- Outputs are driven only from flops; no combinational path from trim or clk to clockp.
- The RTL must not use the `ifdef FUNCTIONAL` path.

Test Plan:
- Defaults, trim = 0, reset pulsed then released before edge 1:
  - clockp[0] rises at edge 28, falls at edge 76, rises at edge 124.
  - clockp[1] rises at edge 52.
  - running goes high at edge 4.
- trim = 26'h3FFFFFF (D = 50): clockp period 200 clk cycles; clockp[1] lags clockp[0] by 50 cycles.
- trim = 26'h0000001 and trim = 26'h2000000 (popcount 1, D = 25): identical outputs, period 100 cycles.
- trim switched from 0 to all-ones 10 cycles into a half-period:
  - Current half-period still ends at 24 cycles.
  - The following half-periods are 50 cycles.
  - No short pulse on either clockp.
- Reset asserted mid-high-phase between clk edges:
  - clockp = 00 and running = 0 immediately.
  - After release, the full NRESET_DELAY + D start-up sequence repeats.
- NRESET_DELAY = 1, BASE_DELAY = 1, trim = 0:
  - clockp[0] toggles every 2 cycles, period 4.
  - clockp[1] is offset by 1 cycle.
